// File: rtl/bar_pattern_pkg.sv
// Shared definitions for the colour-bar test-pattern generator.
//   - mode encodings for the 2-bit pattern select
//   - 8-entry 24-bit RGB palette (8 bits per channel, R in the top byte)
//   - segment tracker state enum
package bar_pattern_pkg;

  localparam logic [1:0] MODE_VBAR    = 2'd0;
  localparam logic [1:0] MODE_HBAR    = 2'd1;
  localparam logic [1:0] MODE_CYCLE   = 2'd2;
  localparam logic [1:0] MODE_OUTLINE = 2'd3;

  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

  // red, green, blue, white, yellow, cyan, magenta, grey
  localparam logic [23:0] PALETTE [8] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h808080
  };

  typedef enum logic [1:0] {
    StGap,
    StBar,
    StTail
  } seg_state_e;

endpackage

// File: rtl/bar_seg_tracker.sv
// Running segment tracker: walks GAP / BAR / TAIL along one axis so bar
// boundaries need no per-bar comparators.
// Ports:
//   VGA_CLK  pixel clock
//   VGA_RST  asynchronous active-high reset (same effect as clear)
//   clear    return to the first gap, counter and index zeroed (wins over step)
//   step     advance one position
//   in_bar   current position lies inside a bar
//   idx      index of the current (or most recent) bar, 0..NUM_BARS-1
module bar_seg_tracker
  import bar_pattern_pkg::*;
#(
  parameter int unsigned SEG      = 420,
  parameter int unsigned GAP      = 5,
  parameter int unsigned NUM_BARS = 3
) (
  input  logic       VGA_CLK,
  input  logic       VGA_RST,
  input  logic       clear,
  input  logic       step,
  output logic       in_bar,
  output logic [2:0] idx
);

  localparam int unsigned MaxLen = (SEG > GAP) ? SEG : GAP;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  localparam logic [CntW-1:0] GapLast = CntW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CntW-1:0] SegLast = CntW'((SEG > 0) ? SEG - 1 : 0);
  localparam logic [2:0]      LastIdx = 3'((NUM_BARS > 0) ? NUM_BARS - 1 : 0);

  // With no gap the gap state is skipped entirely so bars are contiguous.
  localparam seg_state_e StFirst = (GAP == 0) ? StBar : StGap;

  seg_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;

  always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
    if (VGA_RST) begin
      state_q <= StFirst;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = StFirst;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (step) begin
      unique case (state_q)
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StBar;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StBar: begin
          if (cnt_q == SegLast) begin
            cnt_d = '0;
            if (idx_q == LastIdx) begin
              state_d = StTail;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = StFirst;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StTail:  state_d = StTail;
        default: state_d = StFirst;
      endcase
    end
  end

  always_comb begin
    in_bar = (state_q == StBar);
    idx    = idx_q;
  end

endmodule

// File: rtl/bar_pattern_gen.sv
// Parametrised colour-bar test-pattern generator for the VGA pixel path.
// Ports:
//   VGA_CLK  pixel clock
//   VGA_RST  asynchronous active-high reset
//   disp_en  active-video flag from the timing generator
//   x, y     pixel column / row (rows >= V_ACTIVE are vertical blank)
//   mode     pattern select, latched at frame start:
//            0 vertical bars, 1 horizontal bars, 2 palette cycling,
//            3 vertical bars with white gaps
//   r, g, b  registered colour, one cycle after the x/y/disp_en it describes
module bar_pattern_gen
  import bar_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_ACTIVE  = 1024,
  parameter int unsigned NUM_BARS  = 3,
  parameter int unsigned GAP       = 5,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned FRAME_DIV = 30
) (
  input  logic               VGA_CLK,
  input  logic               VGA_RST,
  input  logic               disp_en,
  input  logic [10:0]        x,
  input  logic [10:0]        y,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int unsigned NumDiv = (NUM_BARS == 0) ? 1 : NUM_BARS;
  localparam int BarW = (int'(H_ACTIVE) - int'((NUM_BARS + 1) * GAP)) / int'(NumDiv);
  localparam int BarH = (int'(V_ACTIVE) - int'((NUM_BARS + 1) * GAP)) / int'(NumDiv);
  localparam int unsigned SegW = (BarW > 0) ? unsigned'(BarW) : 1;
  localparam int unsigned SegH = (BarH > 0) ? unsigned'(BarH) : 1;

  localparam int unsigned   FcW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'((FRAME_DIV > 0) ? FRAME_DIV - 1 : 0);

  localparam logic [10:0] HActive11 = 11'(H_ACTIVE);
  localparam logic [10:0] VActive11 = 11'(V_ACTIVE);

  if (NUM_BARS < 1 || NUM_BARS > 8) begin : g_err_num_bars
    $error("bar_pattern_gen: NUM_BARS must be in 1..8");
  end
  if (BarW < 1 || BarH < 1) begin : g_err_bar_size
    $error("bar_pattern_gen: bars do not fit in the active area");
  end
  if (FRAME_DIV < 1) begin : g_err_frame_div
    $error("bar_pattern_gen: FRAME_DIV must be at least 1");
  end

  // MSB-aligned rescale of an 8-bit palette channel to COLOR_W bits.
  function automatic logic [COLOR_W-1:0] scale(input logic [7:0] c);
    logic [COLOR_W+7:0] wide;
    wide = {c, {COLOR_W{1'b0}}};
    return wide[COLOR_W+7 -: COLOR_W];
  endfunction

  logic           vblank, vblank_q, de_q, frame_tick, frame_wrap;
  logic           h_ok_q;
  logic           in_bar_h, in_bar_v;
  logic [2:0]     idx_h, idx_v, cyc_idx;
  logic [1:0]     mode_q, mode_d;
  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]     pal_off_q, pal_off_d;
  logic [23:0]    pix;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  assign vblank     = (y >= VActive11);
  assign frame_tick = vblank_q & ~vblank;

  bar_seg_tracker #(
    .SEG      (SegW),
    .GAP      (GAP),
    .NUM_BARS (NUM_BARS)
  ) u_h_track (
    .VGA_CLK (VGA_CLK),
    .VGA_RST (VGA_RST),
    .clear   (~disp_en),
    .step    (disp_en),
    .in_bar  (in_bar_h),
    .idx     (idx_h)
  );

  // Steps on the falling edge of disp_en, i.e. once per completed line.
  bar_seg_tracker #(
    .SEG      (SegH),
    .GAP      (GAP),
    .NUM_BARS (NUM_BARS)
  ) u_v_track (
    .VGA_CLK (VGA_CLK),
    .VGA_RST (VGA_RST),
    .clear   (vblank),
    .step    (de_q & ~disp_en),
    .in_bar  (in_bar_v),
    .idx     (idx_v)
  );

  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    pal_off_d   = pal_off_q;
    frame_wrap  = (frame_cnt_q == FcLast);
    if (frame_tick) begin
      mode_d      = mode;
      frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
      if (mode != MODE_CYCLE) begin
        pal_off_d = '0;
      end else if (frame_wrap) begin
        pal_off_d = pal_off_q + 3'd1;
      end
    end
  end

  // h_ok_q stays low after reset until the H tracker has seen a blanking
  // cycle; a reset released mid-line would otherwise draw shifted bars.
  // mode_q only leaves MODE_VBAR at a frame tick, by which time vblank has
  // already cleared the V tracker, so no separate V alignment flag is needed.
  always_comb begin
    cyc_idx = idx_h + pal_off_q;
    pix     = RGB_BLACK;
    unique case (mode_q)
      MODE_HBAR:    if (in_bar_v) pix = PALETTE[idx_v];
      MODE_CYCLE:   if (in_bar_h) pix = PALETTE[cyc_idx];
      MODE_OUTLINE: pix = in_bar_h ? PALETTE[idx_h] : RGB_WHITE;
      default:      if (in_bar_h) pix = PALETTE[idx_h];
    endcase
    if (!(disp_en && h_ok_q && (x < HActive11) && !vblank)) begin
      pix = RGB_BLACK;
    end
  end

  always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
    if (VGA_RST) begin
      de_q        <= 1'b0;
      vblank_q    <= 1'b0;
      h_ok_q      <= 1'b0;
      mode_q      <= MODE_VBAR;
      frame_cnt_q <= '0;
      pal_off_q   <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      de_q        <= disp_en;
      vblank_q    <= vblank;
      h_ok_q      <= h_ok_q | ~disp_en;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      pal_off_q   <= pal_off_d;
      r_q         <= scale(pix[23:16]);
      g_q         <= scale(pix[15:8]);
      b_q         <= scale(pix[7:0]);
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule

// File: tb/tb_bar_pattern_gen.sv
// Directed bench for bar_pattern_gen. Three instances share one stimulus:
//   u_def   default parameters (1280x1024, 3 bars, gap 5)
//   u_cyc   40x24, 3 bars, gap 2, FRAME_DIV 2 (bars at x 2..11, 14..23, 26..35)
//   u_eight 1280x1024, 8 bars, gap 0 (160-pixel contiguous bars)
module tb_bar_pattern_gen;

  localparam logic [23:0] BLK = 24'h000000;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] WHT = 24'hFFFFFF;
  localparam logic [23:0] YEL = 24'hFFFF00;
  localparam logic [23:0] CYN = 24'h00FFFF;
  localparam logic [23:0] MAG = 24'hFF00FF;
  localparam logic [23:0] GRY = 24'h808080;

  // Golden mode-0 line for the default instance.
  localparam int          GX [14] = '{0, 4, 5, 424, 425, 429, 430, 849, 850, 854,
                                      855, 1274, 1275, 1279};
  localparam logic [23:0] GC [14] = '{BLK, BLK, RED, RED, BLK, BLK, GRN, GRN, BLK, BLK,
                                      BLU, BLU, BLK, BLK};
  // Golden mode-1 rows for the default instance.
  localparam int          RY [14] = '{0, 4, 5, 338, 339, 343, 344, 677, 678, 682,
                                      683, 1016, 1017, 1023};
  localparam logic [23:0] EIGHT [8] = '{RED, GRN, BLU, WHT, YEL, CYN, MAG, GRY};

  logic        clk = 1'b0;
  logic        rst, de;
  logic [10:0] px, py;
  logic [1:0]  mode;
  logic [7:0]  r_def, g_def, b_def, r_cyc, g_cyc, b_cyc, r_eight, g_eight, b_eight;
  logic [23:0] rgb_def, rgb_cyc, rgb_eight, blank_def;
  logic [23:0] buf_def [0:1279];
  logic [23:0] buf_cyc [0:1279];
  logic [23:0] buf_eight [0:1279];
  logic [23:0] row0 [0:1023];
  logic [23:0] row1 [0:1023];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  assign rgb_def   = {r_def, g_def, b_def};
  assign rgb_cyc   = {r_cyc, g_cyc, b_cyc};
  assign rgb_eight = {r_eight, g_eight, b_eight};

  bar_pattern_gen u_def (
    .VGA_CLK (clk), .VGA_RST (rst), .disp_en (de), .x (px), .y (py), .mode (mode),
    .r (r_def), .g (g_def), .b (b_def)
  );

  bar_pattern_gen #(
    .H_ACTIVE (40), .V_ACTIVE (24), .NUM_BARS (3), .GAP (2), .COLOR_W (8), .FRAME_DIV (2)
  ) u_cyc (
    .VGA_CLK (clk), .VGA_RST (rst), .disp_en (de), .x (px), .y (py), .mode (mode),
    .r (r_cyc), .g (g_cyc), .b (b_cyc)
  );

  bar_pattern_gen #(
    .NUM_BARS (8), .GAP (0)
  ) u_eight (
    .VGA_CLK (clk), .VGA_RST (rst), .disp_en (de), .x (px), .y (py), .mode (mode),
    .r (r_eight), .g (g_eight), .b (b_eight)
  );

  task automatic check_rgb(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Apply one pixel; on return the outputs describe exactly this pixel.
  task automatic step(input logic de_v, input int xv, input int yv);
    de = de_v;
    px = 11'(xv);
    py = 11'(yv);
    @(posedge clk);
    #1;
  endtask

  task automatic vblank_gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1024);
  endtask

  // Two leading blank cycles, nact active pixels, one trailing blank cycle.
  task automatic run_line(input int yv, input int nact);
    step(1'b0, 1280, yv);
    step(1'b0, 1281, yv);
    for (int xi = 0; xi < nact; xi++) begin
      step(1'b1, xi, yv);
      buf_def[xi]   = rgb_def;
      buf_cyc[xi]   = rgb_cyc;
      buf_eight[xi] = rgb_eight;
    end
    step(1'b0, nact, yv);
    blank_def = rgb_def;
  endtask

  task automatic check_line(input string pfx, input logic outline);
    for (int i = 0; i < 14; i++) begin
      check_rgb($sformatf("%s x=%0d", pfx, GX[i]), buf_def[GX[i]],
                (outline && GC[i] == BLK) ? WHT : GC[i]);
    end
  endtask

  task automatic check_cyc(input int f, input logic [23:0] c0, input logic [23:0] c1,
                           input logic [23:0] c2);
    check_rgb($sformatf("cycle f=%0d bar0", f), buf_cyc[6],  c0);
    check_rgb($sformatf("cycle f=%0d bar1", f), buf_cyc[18], c1);
    check_rgb($sformatf("cycle f=%0d bar2", f), buf_cyc[30], c2);
  endtask

  initial begin
    rst  = 1'b1;
    de   = 1'b0;
    px   = '0;
    py   = '0;
    mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_rgb("reset def", rgb_def, BLK);
    check_rgb("reset eight", rgb_eight, BLK);
    rst = 1'b0;

    // Mode 0 golden line on all instances.
    run_line(0, 1280);
    check_line("m0", 1'b0);
    check_rgb("blank after line", blank_def, BLK);
    check_rgb("cyc x=1", buf_cyc[1], BLK);
    check_rgb("cyc x=2", buf_cyc[2], RED);
    check_rgb("cyc x=11", buf_cyc[11], RED);
    check_rgb("cyc x=12", buf_cyc[12], BLK);
    check_rgb("cyc x=18", buf_cyc[18], GRN);
    check_rgb("cyc x=30", buf_cyc[30], BLU);
    check_rgb("cyc x=36", buf_cyc[36], BLK);
    for (int k = 0; k < 8; k++) begin
      check_rgb($sformatf("eight x=%0d", 160 * k), buf_eight[160 * k], EIGHT[k]);
      check_rgb($sformatf("eight x=%0d", 160 * k + 159), buf_eight[160 * k + 159], EIGHT[k]);
    end
    step(1'b0, 200, 1);
    check_rgb("de low in bar", rgb_def, BLK);

    // Mode 1: horizontal bars, short lines, one frame.
    mode = 2'd1;
    vblank_gap(2);
    for (int yi = 0; yi < 1024; yi++) begin
      step(1'b0, 1280, yi);
      step(1'b1, 0, yi);
      row0[yi] = rgb_def;
      step(1'b1, 1, yi);
      row1[yi] = rgb_def;
      step(1'b0, 2, yi);
    end
    for (int i = 0; i < 14; i++) begin
      check_rgb($sformatf("m1 row=%0d", RY[i]), row0[RY[i]], GC[i]);
    end
    check_rgb("m1 row=5 x=1", row1[5], RED);
    check_rgb("m1 row=400 x=1", row1[400], GRN);
    check_rgb("m1 row=1020 x=1", row1[1020], BLK);

    // Mode change 0->3 mid-frame takes effect only at the next frame.
    mode = 2'd0;
    vblank_gap(2);
    run_line(0, 1280);
    mode = 2'd3;
    run_line(500, 1280);
    check_line("m3 held", 1'b0);
    vblank_gap(2);
    run_line(0, 1280);
    check_line("m3", 1'b1);

    // Asynchronous reset mid-line at x=600, y=400.
    step(1'b0, 1280, 400);
    step(1'b0, 1281, 400);
    for (int xi = 0; xi <= 600; xi++) step(1'b1, xi, 400);
    check_rgb("pre-reset x=600", rgb_def, GRN);
    #2 rst = 1'b1;
    #1;
    check_rgb("async reset", rgb_def, BLK);
    for (int xi = 601; xi < 610; xi++) step(1'b1, xi, 400);
    rst = 1'b0;
    for (int xi = 610; xi < 1280; xi++) begin
      step(1'b1, xi, 400);
      buf_def[xi] = rgb_def;
    end
    step(1'b0, 1280, 400);
    check_rgb("post-release x=620", buf_def[620], BLK);
    check_rgb("post-release x=1000", buf_def[1000], BLK);
    mode = 2'd0;
    vblank_gap(2);
    run_line(0, 1280);
    check_line("after reset", 1'b0);

    // Palette cycling on the small instance, FRAME_DIV = 2.
    step(1'b0, 0, 1024);
    rst = 1'b1;
    step(1'b0, 0, 1024);
    step(1'b0, 0, 1024);
    rst = 1'b0;
    for (int f = 1; f <= 20; f++) begin
      mode = (f == 19) ? 2'd0 : 2'd2;
      vblank_gap(2);
      run_line(0, 40);
      case (f)
        1:       check_cyc(f, RED, GRN, BLU);
        2, 3:    check_cyc(f, GRN, BLU, WHT);
        4:       check_cyc(f, BLU, WHT, YEL);
        15:      check_cyc(f, GRY, RED, GRN);
        16, 17:  check_cyc(f, RED, GRN, BLU);
        18:      check_cyc(f, GRN, BLU, WHT);
        19:      check_cyc(f, RED, GRN, BLU);
        20:      check_cyc(f, GRN, BLU, WHT);
        default: ;
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
